backprop_weight_update: RTL and testbench

Backward-pass counterpart to the hidden-neuron forward path. On each backward-pass request from the training state machine (b_pass_o), it captures the output-neuron error and the 4-bit input vector. It then updates the four hidden-neuron weights serially, one per cycle, using a shift-scaled learning rate and saturating arithmetic. Its weight outputs replace the constant weight ties on the hidden neurons' w0_i..w3_i.

---
 rtl/backprop_weight_update.sv | 139 +++++++++++++
 tb/tb_backprop_weight_update.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/backprop_weight_update.sv
// Serial backward-pass weight updater: captures error and input features on a
// start request, then rewrites one hidden-neuron weight per cycle with saturation.
module backprop_weight_update #(
  parameter int WEIGHT_W = 8,
  parameter int ERR_W    = 12,
  parameter int LR_SHIFT = 2,
  parameter int W0_INIT  = 1,
  parameter int W1_INIT  = 2,
  parameter int W2_INIT  = 3,
  parameter int W3_INIT  = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic                init_i,
  input  logic                start_i,
  input  logic [ERR_W-1:0]    err_i,
  input  logic [3:0]          x_i,
  output logic [WEIGHT_W-1:0] w0_o,
  output logic [WEIGHT_W-1:0] w1_o,
  output logic [WEIGHT_W-1:0] w2_o,
  output logic [WEIGHT_W-1:0] w3_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                sat_o
);

  localparam int SUM_W = WEIGHT_W + ERR_W + 1;
  localparam logic signed [SUM_W-1:0] W_MAX = SUM_W'((1 << (WEIGHT_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] W_MIN = ~W_MAX;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    UPD0 = 3'd1,
    UPD1 = 3'd2,
    UPD2 = 3'd3,
    UPD3 = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic signed [ERR_W-1:0]    err_q;
  logic [3:0]                 x_q;
  logic signed [WEIGHT_W-1:0] w_q [4];
  logic                       done_q;
  logic                       sat_q;

  logic [1:0]                 upd_idx;
  logic                       upd_act;
  logic signed [ERR_W-1:0]    delta;
  logic signed [SUM_W-1:0]    upd_sum;
  logic signed [WEIGHT_W-1:0] upd_w;
  logic                       upd_clamp;
  logic                       upd_wr;

  function automatic logic signed [WEIGHT_W-1:0] sat_clamp(input logic signed [SUM_W-1:0] v);
    if (v > W_MAX)      sat_clamp = W_MAX[WEIGHT_W-1:0];
    else if (v < W_MIN) sat_clamp = W_MIN[WEIGHT_W-1:0];
    else                sat_clamp = v[WEIGHT_W-1:0];
  endfunction

  function automatic logic sat_hit(input logic signed [SUM_W-1:0] v);
    sat_hit = (v > W_MAX) || (v < W_MIN);
  endfunction

  always_comb begin
    state_nxt = state;
    upd_idx   = 2'd0;
    upd_act   = 1'b0;
    case (state)
      IDLE: if (start_i) state_nxt = UPD0;
      UPD0: begin state_nxt = UPD1; upd_idx = 2'd0; upd_act = 1'b1; end
      UPD1: begin state_nxt = UPD2; upd_idx = 2'd1; upd_act = 1'b1; end
      UPD2: begin state_nxt = UPD3; upd_idx = 2'd2; upd_act = 1'b1; end
      UPD3: begin state_nxt = IDLE; upd_idx = 2'd3; upd_act = 1'b1; end
      default: state_nxt = IDLE;
    endcase
  end

  // Update datapath: floor-scaled error subtracted at full width, then clamped
  always_comb begin
    delta     = err_q >>> LR_SHIFT;
    upd_sum   = $signed({{(SUM_W-WEIGHT_W){w_q[upd_idx][WEIGHT_W-1]}}, w_q[upd_idx]})
              - $signed({{(SUM_W-ERR_W){delta[ERR_W-1]}}, delta});
    upd_w     = sat_clamp(upd_sum);
    upd_clamp = sat_hit(upd_sum);
    upd_wr    = upd_act && x_q[upd_idx];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state <= IDLE;
    end else if (en_i) begin
      if (init_i) state <= IDLE;
      else        state <= state_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      err_q  <= '0;
      x_q    <= '0;
      done_q <= 1'b0;
      sat_q  <= 1'b0;
      w_q[0] <= WEIGHT_W'(W0_INIT);
      w_q[1] <= WEIGHT_W'(W1_INIT);
      w_q[2] <= WEIGHT_W'(W2_INIT);
      w_q[3] <= WEIGHT_W'(W3_INIT);
    end else if (en_i) begin
      if (init_i) begin
        done_q <= 1'b0;
        sat_q  <= 1'b0;
        w_q[0] <= WEIGHT_W'(W0_INIT);
        w_q[1] <= WEIGHT_W'(W1_INIT);
        w_q[2] <= WEIGHT_W'(W2_INIT);
        w_q[3] <= WEIGHT_W'(W3_INIT);
      end else begin
        done_q <= (state == UPD3);
        if (state == IDLE && start_i) begin
          err_q <= $signed(err_i);
          x_q   <= x_i;
        end
        if (upd_wr) begin
          w_q[upd_idx] <= upd_w;
          if (upd_clamp) sat_q <= 1'b1;
        end
      end
    end
  end

  assign w0_o   = w_q[0];
  assign w1_o   = w_q[1];
  assign w2_o   = w_q[2];
  assign w3_o   = w_q[3];
  assign busy_o = (state != IDLE);
  assign done_o = done_q;
  assign sat_o  = sat_q;

endmodule

// File: tb/tb_backprop_weight_update.sv
// Directed bench for backprop_weight_update with hand-computed expectations.
module tb_backprop_weight_update;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        en_i = 1'b1;
  logic        init_i = 1'b0;
  logic        start_i = 1'b0;
  logic [11:0] err_i = '0;
  logic [3:0]  x_i = '0;
  logic [7:0]  w0_o, w1_o, w2_o, w3_o;
  logic        busy_o, done_o, sat_o;

  int n_chk = 0;
  int n_err = 0;

  backprop_weight_update dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .init_i(init_i),
    .start_i(start_i), .err_i(err_i), .x_i(x_i),
    .w0_o(w0_o), .w1_o(w1_o), .w2_o(w2_o), .w3_o(w3_o),
    .busy_o(busy_o), .done_o(done_o), .sat_o(sat_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_w(input string tag, input int a, input int b, input int c, input int d);
    chk({tag, ".w0"}, int'($signed(w0_o)), a);
    chk({tag, ".w1"}, int'($signed(w1_o)), b);
    chk({tag, ".w2"}, int'($signed(w2_o)), c);
    chk({tag, ".w3"}, int'($signed(w3_o)), d);
  endtask

  task automatic chk_ctl(input string tag, input int b, input int dn, input int s);
    chk({tag, ".busy"}, int'(busy_o), b);
    chk({tag, ".done"}, int'(done_o), dn);
    chk({tag, ".sat"},  int'(sat_o), s);
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    step();
    step();
    rst_i = 1'b1;
  endtask

  // Pulse start for one edge, then run the four update edges.
  task automatic run_seq(input int err, input logic [3:0] x);
    err_i   = 12'(err);
    x_i     = x;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    repeat (4) step();
  endtask

  initial begin
    do_reset();

    // 1: idle after reset
    repeat (5) step();
    chk_w("reset", 1, 2, 3, 4);
    chk_ctl("reset", 0, 0, 0);

    // 2: err=8 (delta=2), all features set
    err_i = 12'd8; x_i = 4'b1111; start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("t2.busyE0", int'(busy_o), 1);
    chk_w("t2.E0", 1, 2, 3, 4);
    step(); chk_w("t2.E1", -1, 2, 3, 4); chk("t2.busyE1", int'(busy_o), 1);
    step(); chk_w("t2.E2", -1, 0, 3, 4); chk("t2.doneE2", int'(done_o), 0);
    step(); chk_w("t2.E3", -1, 0, 1, 4); chk("t2.busyE3", int'(busy_o), 1);
    step(); chk_w("t2.E4", -1, 0, 1, 2); chk_ctl("t2.E4", 0, 1, 0);
    step(); chk("t2.doneE5", int'(done_o), 0);

    // 3: negative error, partial features, input change mid-sequence ignored
    do_reset();
    err_i = -12'sd20; x_i = 4'b0101; start_i = 1'b1;
    step();
    start_i = 1'b0;
    step();
    err_i = 12'd0; x_i = 4'b1111;
    repeat (3) step();
    chk_w("t3.a", 6, 2, 8, 4);
    chk("t3.a.done", int'(done_o), 1);
    run_seq(-1, 4'b0001);
    chk_w("t3.b", 7, 2, 8, 4);
    chk("t3.b.sat", int'(sat_o), 0);

    // 4: saturation both directions, sticky flag, cleared by init
    do_reset();
    run_seq(2047, 4'b1000);
    chk_w("t4.a", 1, 2, 3, -128);
    chk("t4.a.sat", int'(sat_o), 1);
    run_seq(-2048, 4'b1111);
    chk_w("t4.b", 127, 127, 127, 127);
    chk("t4.b.sat", int'(sat_o), 1);
    init_i = 1'b1;
    step();
    init_i = 1'b0;
    chk_w("t4.init", 1, 2, 3, 4);
    chk("t4.init.sat", int'(sat_o), 0);

    // 5: start held -> back-to-back sequences, done after E4 and E9
    do_reset();
    err_i = 12'd4; x_i = 4'b0001; start_i = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      if (k == 9) start_i = 1'b0;
      chk($sformatf("t5.done%0d", k), int'(done_o), (k == 4 || k == 9) ? 1 : 0);
    end
    chk_w("t5", -1, 2, 3, 4);
    chk("t5.busy", int'(busy_o), 0);

    // 6a: enable low for 3 cycles in UPD1
    do_reset();
    err_i = 12'd8; x_i = 4'b1111; start_i = 1'b1;
    step();
    start_i = 1'b0;
    step();
    en_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_w($sformatf("t6a.hold%0d", k), -1, 2, 3, 4);
      chk_ctl($sformatf("t6a.hold%0d", k), 1, 0, 0);
    end
    en_i = 1'b1;
    step(); chk_w("t6a.E2", -1, 0, 3, 4);
    step(); chk("t6a.E3.done", int'(done_o), 0);
    step(); chk_w("t6a.E4", -1, 0, 1, 2); chk_ctl("t6a.E4", 0, 1, 0);
    step();

    // 6b: init in UPD2 aborts without done
    err_i = 12'd8; x_i = 4'b1111; start_i = 1'b1;
    step();
    start_i = 1'b0;
    step(); step();
    chk_w("t6b.pre", -3, -2, 1, 2);
    init_i = 1'b1;
    step();
    init_i = 1'b0;
    chk_w("t6b.init", 1, 2, 3, 4);
    chk_ctl("t6b.init", 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("t6b.nodone%0d", k), int'(done_o), 0);
    end

    // 6c: reset in UPD3, with en low to show reset wins
    err_i = 12'd8; x_i = 4'b1111; start_i = 1'b1;
    step();
    start_i = 1'b0;
    step(); step(); step();
    chk_w("t6c.pre", -1, 0, 1, 4);
    rst_i = 1'b0; en_i = 1'b0;
    step();
    rst_i = 1'b1; en_i = 1'b1;
    chk_w("t6c.rst", 1, 2, 3, 4);
    chk_ctl("t6c.rst", 0, 0, 0);
    step();
    chk("t6c.nodone", int'(done_o), 0);
    chk_w("t6c.after", 1, 2, 3, 4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
